serial_word_collector: RTL and testbench
========================================

# serial_word_collector

Serial-to-parallel collector that is the inverse of the 8:1 bit selector used in the 8-bit multiplier datapath. A bit stream arrives one bit per accepted cycle. A 3-bit index (s2:s0 order) steers each bit into its slot of an 8-bit shadow word. When all eight slots are filled, the shadow word transfers to an output register and is presented with a valid/ready handshake. It sits after the serial product path and rebuilds bytes for the multiplier result bus.

## Interface
- LSB_FIRST, default 1: 1 = first accepted bit goes to slot 0 and the index counts up; 0 = first bit goes to slot 7 and the index counts down.
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- bit_in  in  1  serial data bit.
- bit_valid  in  1  bit_in is valid this cycle.
- bit_ready  out  1  the collector can accept a bit this cycle.
- clr  in  1  synchronous abort of the partial word.
- idx  out  3  slot the next accepted bit will be written to.
- word_out  out  8  assembled word; stable while word_valid=1.
- word_valid  out  1  word_out holds an unread word.
- word_ready  in  1  the consumer takes word_out this cycle.
- busy  out  1  at least one bit of a partial word is stored.

## Operation
- A bit is accepted when bit_valid and bit_ready are both 1. The accepted bit is written to shadow[idx], then idx advances by one step (up or down per LSB_FIRST).
- On the 8th accepted bit, the completed word (the previous 7 bits plus this bit) loads into word_out, word_valid is set, idx returns to its start value (0 or 7), and the shadow word clears.
- Double buffered: a new word fills while the previous word waits at the output.
- bit_ready = 0 only when the next accepted bit would be the 8th, word_valid=1, and word_ready=0. Otherwise bit_ready=1.
- A word is taken when word_valid and word_ready are both 1. word_valid then clears, unless a completed word loads in the same cycle; in that case word_valid stays 1 and word_out takes the new word.
- clr clears idx and the shadow word and drops busy. It has priority over a bit accepted in the same cycle; that bit is discarded. clr does not touch word_out or word_valid.
- State machine, stored explicitly:
  - FILL: no bits held (busy=0) or a partial word held (busy=1).
  - STALL: the 8th bit is pending and the output is full.
  - FILL -> STALL when idx is at its last slot and word_valid=1 and word_ready=0.
  - STALL -> FILL when word_ready=1. bit_ready rises in that same cycle, combinationally from word_ready.
- Out-of-range states decode to FILL.

## Timing
- Reset values: idx = 0 (LSB_FIRST=1) or 7 (LSB_FIRST=0); word_out=0; word_valid=0; busy=0; bit_ready=1; shadow=0; state FILL.
- Latency: word_valid is high in the cycle after the 8th bit is accepted.
- Throughput: one bit per cycle. With word_ready tied high the stream never stalls.
- Reset mid-word: the partial word and any unread output word are lost, with no handshake.
- word_out and word_valid are registered. bit_ready is combinational from state, word_valid and word_ready.
- busy=1 from the cycle after the first accepted bit until the word completes or clr is applied.

## Configuration
- SERIAL_COLLECTOR_PARITY_EN
  - Defined: each word is 9 accepted bits, 8 data bits followed by one even-parity bit. An extra output par_err (1 bit, registered, reset 0) loads together with word_out. par_err = 1 when the XOR of the 8 data bits and the parity bit is 1. The stall condition applies to the 9th bit instead of the 8th. A 4-bit internal counter tracks the parity slot; idx stays at its start value during the parity bit.
  - Undefined: 8-bit words only. par_err and the parity logic are absent.

## Structure
- Shared package holds:
  - WORD_W = 8 and IDX_W = 3.
  - The state enum (FILL, STALL).
  - Start/end index constants per bit order.
- Sub-module bit_demux8: combinational 3-to-8 decoder. It turns the index (s0, s1, s2) and a write strobe into a one-hot slot write enable, the mirror of the 8:1 selector.
- The top level holds the counter, the shadow register, the output register and the state machine.

## Test plan
- LSB_FIRST=1, word_ready=1, stream 1,0,1,1,0,0,1,0 -> word_out=8'h4D with word_valid=1 for exactly one cycle; idx cycles 0..7 back to 0.
- LSB_FIRST=0, same stream -> word_out=8'hB2.
- word_ready=0, stream 16 bits (8'hFF then 8'h0F) -> first word held at 8'hFF; bit_ready=0 when the 16th bit is offered.
  - Then word_ready=1 for one cycle -> the 16th bit is accepted in that cycle, and word_out=8'h0F the next cycle.
- 3 bits accepted, then clr together with bit_valid=1 -> idx=0, busy=0, that bit discarded. The next 8 bits form a clean word.
- Last bit accepted in the same cycle as word_ready=1 with word_valid=1 -> word_valid stays 1 and word_out updates with no gap.
- rst asserted after 5 bits with an unread output word -> all outputs return to their reset values on the next edge.
- With SERIAL_COLLECTOR_PARITY_EN: data 8'hA5 with parity 0 -> par_err=0; the same data with parity 1 -> par_err=1.

Source files
------------

// File: rtl/serial_word_collector_pkg.sv
// Shared definitions for the serial word collector.
//   WORD_W / IDX_W        : word width and slot index width
//   state_e               : collector state (FILL, STALL)
//   IDX_START_* / IDX_END_*: first and last slot for each bit order
package serial_word_collector_pkg;

  localparam int WORD_W = 8;
  localparam int IDX_W  = 3;

  // Two-bit encoding so that illegal codes exist and can decode to FILL.
  typedef enum logic [1:0] {
    FILL  = 2'b01,
    STALL = 2'b10
  } state_e;

  localparam logic [IDX_W-1:0] IDX_START_LSB = 3'd0;
  localparam logic [IDX_W-1:0] IDX_END_LSB   = 3'd7;
  localparam logic [IDX_W-1:0] IDX_START_MSB = 3'd7;
  localparam logic [IDX_W-1:0] IDX_END_MSB   = 3'd0;

endpackage

// File: rtl/serial_word_collector_bit_demux8.sv
// bit_demux8: combinational 3-to-8 decoder, the mirror of the 8:1 bit
// selector. Turns a slot index (sel[0]=s0, sel[1]=s1, sel[2]=s2) and a
// write strobe into a one-hot slot write enable.
//   sel : slot index
//   we  : write strobe
//   wen : one-hot write enable, all zero when we=0
module bit_demux8
  import serial_word_collector_pkg::*;
(
  input  logic [IDX_W-1:0]  sel,
  input  logic              we,
  output logic [WORD_W-1:0] wen
);

  always_comb begin
    wen = '0;
    if (we) wen[sel] = 1'b1;
  end

endmodule

// File: rtl/serial_word_collector.sv
// serial_word_collector: serial-to-parallel byte collector. Each accepted
// bit is steered into shadow[idx]; the completed word moves to a registered
// output held under a valid/ready handshake while the next word fills.
// Optional feature macro: SERIAL_COLLECTOR_PARITY_EN (9-bit words: 8 data
// bits then an even-parity bit, reported on par_err).
//   clk, rst              : clock, synchronous active-high reset
//   bit_in/bit_valid/bit_ready : serial input handshake
//   clr                   : abort the partial word
//   idx                   : slot for the next accepted bit
//   word_out/word_valid/word_ready : output word handshake
//   busy                  : a partial word is held
//   par_err               : parity error of word_out (parity build only)
module serial_word_collector
  import serial_word_collector_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              bit_ready,
  input  logic              clr,
  output logic [IDX_W-1:0]  idx,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ready,
`ifdef SERIAL_COLLECTOR_PARITY_EN
  output logic              par_err,
`endif
  output logic              busy
);

  localparam logic [IDX_W-1:0] IDX_START = LSB_FIRST ? IDX_START_LSB : IDX_START_MSB;
  localparam logic [IDX_W-1:0] IDX_END   = LSB_FIRST ? IDX_END_LSB   : IDX_END_MSB;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] shadow_q, shadow_d, word_q, word_d;
  logic [WORD_W-1:0] wen, shadow_wr;
  logic              word_valid_q, word_valid_d;
  logic              last_slot, par_slot, accept, complete, take, stall_st;

`ifdef SERIAL_COLLECTOR_PARITY_EN
  logic [3:0] cnt_q, cnt_d;
  logic       par_err_q, par_err_d;
  // The ninth bit carries parity; idx has already wrapped to its start.
  assign par_slot  = (cnt_q == 4'(WORD_W));
  assign last_slot = par_slot;
  assign busy      = (cnt_q != 4'd0);
  assign par_err   = par_err_q;
`else
  assign par_slot  = 1'b0;
  assign last_slot = (idx_q == IDX_END);
  assign busy      = (idx_q != IDX_START);
`endif

  assign stall_st = (state_q == STALL);
  // Hold off only the word-completing bit while the output is still full.
  assign bit_ready = !((stall_st || last_slot) && word_valid_q && !word_ready);
  assign accept    = bit_valid && bit_ready && !clr;
  assign complete  = accept && last_slot;
  assign take      = word_valid_q && word_ready;

  bit_demux8 u_demux (
    .sel (idx_q),
    .we  (accept && !par_slot),
    .wen (wen)
  );

  // Shadow word with the current bit merged in; this is what loads on completion.
  assign shadow_wr = (shadow_q & ~wen) | (wen & {WORD_W{bit_in}});

  always_comb begin
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    word_d       = word_q;
    word_valid_d = word_valid_q;
    if (take) word_valid_d = 1'b0;
    if (clr) begin
      idx_d    = IDX_START;
      shadow_d = '0;
    end else if (accept) begin
      shadow_d = shadow_wr;
      if (!par_slot) idx_d = LSB_FIRST ? idx_q + 3'd1 : idx_q - 3'd1;
      if (complete) begin
        word_d       = shadow_wr;
        word_valid_d = 1'b1;
        shadow_d     = '0;
        idx_d        = IDX_START;
      end
    end
  end

`ifdef SERIAL_COLLECTOR_PARITY_EN
  always_comb begin
    cnt_d     = cnt_q;
    par_err_d = par_err_q;
    if (clr)         cnt_d = 4'd0;
    else if (accept) cnt_d = complete ? 4'd0 : cnt_q + 4'd1;
    if (complete)    par_err_d = (^shadow_q) ^ bit_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= 4'd0;
      par_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      par_err_q <= par_err_d;
    end
  end
`endif

  always_comb begin
    state_d = FILL;
    case (state_q)
      FILL:    state_d = (last_slot && word_valid_q && !word_ready && !clr) ? STALL : FILL;
      STALL:   state_d = (word_ready || clr) ? FILL : STALL;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FILL;
      idx_q        <= IDX_START;
      shadow_q     <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign idx        = idx_q;
  assign word_out   = word_q;
  assign word_valid = word_valid_q;

endmodule

// File: tb/tb_serial_word_collector.sv
module tb_serial_word_collector;

`ifdef SERIAL_COLLECTOR_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic clk = 1'b0;
  logic rst, bit_in, bit_valid, clr, word_ready;
  logic br_l, br_m, wv_l, wv_m, busy_l, busy_m;
  logic [2:0] idx_l, idx_m;
  logic [7:0] wo_l, wo_m;
`ifdef SERIAL_COLLECTOR_PARITY_EN
  logic pe_l, pe_m;
`endif

  typedef struct packed { logic [7:0] w; logic pe; } exp_t;
  exp_t q_l[$];
  exp_t q_m[$];
  bit   part[$];   // bits of the word being collected, in arrival order
  bit   out_full;  // model: an unread word sits at the output
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_word_collector #(.LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(br_l),
    .clr(clr), .idx(idx_l), .word_out(wo_l), .word_valid(wv_l), .word_ready(word_ready),
`ifdef SERIAL_COLLECTOR_PARITY_EN
    .par_err(pe_l),
`endif
    .busy(busy_l));

  serial_word_collector #(.LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(br_m),
    .clr(clr), .idx(idx_m), .word_out(wo_m), .word_valid(wv_m), .word_ready(word_ready),
`ifdef SERIAL_COLLECTOR_PARITY_EN
    .par_err(pe_m),
`endif
    .busy(busy_m));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Registered outputs against the model state.
  task automatic check_state();
    int s;
    s = part.size() % 8;
    chk("idx_lsb", idx_l, s);
    chk("idx_msb", idx_m, 7 - s);
    chk("busy_lsb", busy_l, part.size() != 0);
    chk("busy_msb", busy_m, part.size() != 0);
    chk("word_valid_lsb", wv_l, out_full);
    chk("word_valid_msb", wv_m, out_full);
  endtask

  // One cycle of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic step(input bit v, input bit b, input bit wr, input bit c, output bit acc);
    bit rdy, done;
    exp_t el, em;
    check_state();
    bit_valid = v; bit_in = b; word_ready = wr; clr = c;
    #1;
    rdy = !(part.size() == NB - 1 && out_full && !wr);
    chk("bit_ready_lsb", br_l, rdy);
    chk("bit_ready_msb", br_m, rdy);
    acc  = v && rdy && !c;
    done = 1'b0;
    if (c) part.delete();
    else if (acc) begin
      part.push_back(b);
      if (part.size() == NB) begin
        el = '0; em = '0;
        for (int i = 0; i < 8; i++) begin
          el.w[i]     = part[i];
          em.w[7 - i] = part[i];
        end
        for (int i = 0; i < NB; i++) el.pe ^= part[i];
        em.pe = el.pe;
        q_l.push_back(el);
        q_m.push_back(em);
        part.delete();
        done = 1'b1;
      end
    end
    out_full = done || (out_full && !wr);
    @(posedge clk); #1;
  endtask

  task automatic send_bit(input bit b, input bit wr);
    bit acc;
    int n;
    n = 0;
    do begin
      step(1'b1, b, wr, 1'b0, acc);
      n++;
    end while (!acc && n < 50);
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_bit: bit never accepted, got bit_ready=%0b required 1", br_l);
    end
  endtask

  function automatic bit wbit(input logic [7:0] d, input bit par, input int k);
    logic [7:0] t;
    t = d;
    return (k < 8) ? t[k] : par;
  endfunction

  task automatic send_word(input logic [7:0] d, input bit par, input bit wr);
    for (int k = 0; k < NB; k++) send_bit(wbit(d, par, k), wr);
  endtask

  task automatic idle(input int n, input bit wr);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, wr, 1'b0, acc);
  endtask

  task automatic do_reset();
    rst = 1'b1; bit_valid = 1'b0; word_ready = 1'b0; clr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    part.delete(); out_full = 1'b0; q_l.delete(); q_m.delete();
    check_state();
    chk("reset_word_lsb", wo_l, 8'h00);
    chk("reset_word_msb", wo_m, 8'h00);
`ifdef SERIAL_COLLECTOR_PARITY_EN
    chk("reset_par_err", pe_l, 1'b0);
`endif
  endtask

  // Scoreboard monitor: every handshake pops one expected word.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && word_ready && wv_l) begin
      if (q_l.size() == 0) begin
        checks++; errors++;
        $display("FAIL lsb_word: got %0h, required no word", wo_l);
      end else begin
        e = q_l.pop_front();
        chk("lsb_word", wo_l, e.w);
`ifdef SERIAL_COLLECTOR_PARITY_EN
        chk("lsb_par_err", pe_l, e.pe);
`endif
      end
    end
    if (!rst && word_ready && wv_m) begin
      if (q_m.size() == 0) begin
        checks++; errors++;
        $display("FAIL msb_word: got %0h, required no word", wo_m);
      end else begin
        e = q_m.pop_front();
        chk("msb_word", wo_m, e.w);
`ifdef SERIAL_COLLECTOR_PARITY_EN
        chk("msb_par_err", pe_m, e.pe);
`endif
      end
    end
  end

  initial begin
    bit acc;
    logic [7:0] d;
    rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; clr = 1'b0; word_ready = 1'b0;
    out_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Stream 1,0,1,1,0,0,1,0 with the consumer always ready.
    send_word(8'h4D, 1'b0, 1'b1);
    idle(3, 1'b1);

    // Output full: the completing bit of the second word must wait.
    send_word(8'hFF, 1'b0, 1'b0);
    for (int k = 0; k < NB - 1; k++) send_bit(wbit(8'h0F, 1'b0, k), 1'b0);
    step(1'b1, wbit(8'h0F, 1'b0, NB - 1), 1'b0, 1'b0, acc);
    step(1'b1, wbit(8'h0F, 1'b0, NB - 1), 1'b0, 1'b0, acc);
    step(1'b1, wbit(8'h0F, 1'b0, NB - 1), 1'b1, 1'b0, acc);
    idle(1, 1'b0);
    idle(2, 1'b1);

    // Abort after three bits; the bit offered with clr is dropped.
    send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, acc);
    send_word(8'h3C, 1'b0, 1'b1);
    idle(2, 1'b1);

    // Completion in the same cycle the previous word is taken.
    send_word(8'h96, 1'b0, 1'b0);
    for (int k = 0; k < NB - 1; k++) send_bit(wbit(8'h5A, 1'b0, k), 1'b0);
    send_bit(wbit(8'h5A, 1'b0, NB - 1), 1'b1);
    idle(1, 1'b0);
    idle(2, 1'b1);

    // Reset with an unread word and a partial word.
    send_word(8'hC3, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) send_bit(1'b1, 1'b0);
    do_reset();

    // Parity cases (data bits only in the 8-bit build).
    send_word(8'hA5, 1'b0, 1'b1);
    send_word(8'hA5, 1'b1, 1'b1);
    idle(2, 1'b1);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 3) != 0), $urandom_range(0, 1),
           (i < 700) ? 1'b1 : ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 40) == 0), acc);
    end
    idle(4, 1'b1);
    chk("lsb_queue_empty", q_l.size(), 0);
    chk("msb_queue_empty", q_m.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
